// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues word requests to instruction memory
// and buffers returned words with their PCs in an in-order FIFO.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [31:0]     pc_mem   [FIFO_DEPTH];
  logic [31:0]     data_mem [FIFO_DEPTH];

  logic            issue;
  logic            rsp;
  logic            push;
  logic            pop;
  logic [CW:0]     credit_used;
  logic [CW-1:0]   n_next;
  logic [31:0]     rsp_pc;
  logic [31:0]     target;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign imem_req    = !reset && !redirect && (state == RUN)
                    && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr   = fetch_pc;
  assign issue       = imem_req && imem_gnt;
  assign rsp         = imem_rvalid && (outstanding != '0);
  assign push        = rsp && (state == RUN) && !redirect;
  assign instr_valid = (state == RUN) && (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign instr       = data_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];
  assign target      = redirect_pc & 32'hFFFF_FFFC;
  assign n_next      = outstanding + CW'(issue) - CW'(rsp);

  // In RUN all in-flight requests are consecutive words behind fetch_pc.
  assign rsp_pc = fetch_pc - (32'(outstanding) << 2);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      outstanding <= n_next;
      if (redirect) begin
        fetch_pc <= target;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        drop_cnt <= n_next;
        state    <= (n_next != '0) ? DRAIN : RUN;
      end else begin
        if (issue)
          fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          pc_mem[wr_ptr]   <= rsp_pc;
          data_mem[wr_ptr] <= imem_rdata;
          wr_ptr           <= bump(wr_ptr);
        end
        if (pop)
          rd_ptr <= bump(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
        case (state)
          DRAIN: begin
            if (rsp && (drop_cnt != '0))
              drop_cnt <= drop_cnt - CW'(1);
            if ((drop_cnt == '0) || (rsp && (drop_cnt == CW'(1))))
              state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a stream-level
// model: after each reset/redirect the word stream restarts at the target.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  instruction_fetch_unit #(
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed;
  int total;
  int cyc;
  int rv_pct;
  int n_grants;
  int n_pops;

  logic [31:0] mq_a [$];
  int          mq_c [$];
  logic [31:0] exp_i;
  logic [31:0] exp_p;
  logic        hold;
  logic [31:0] hold_addr;

  logic        s_req;
  logic        s_issue;
  logic [31:0] s_addr;
  logic        s_valid;
  logic [31:0] s_pc;
  logic [31:0] s_instr;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  task automatic cycle();
    logic rv;
    rv = 1'b0;
    if (!reset && mq_a.size() > 0 && mq_c[0] < cyc
        && $urandom_range(0, 99) < rv_pct)
      rv = 1'b1;
    imem_rvalid = rv;
    imem_rdata  = rv ? word(mq_a[0]) : 32'hDEAD_BEEF;
    #1;
    s_req   = imem_req;
    s_issue = imem_req && imem_gnt;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_pc    = instr_pc;
    s_instr = instr;
    check("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
    if (reset) begin
      check("req_in_reset", {31'b0, imem_req}, 32'h0);
      exp_i = RST_PC;
      exp_p = RST_PC;
      mq_a.delete();
      mq_c.delete();
      hold = 1'b0;
    end else begin
      if (hold && !redirect) begin
        check("req_hold", {31'b0, imem_req}, 32'h1);
        check("addr_hold", imem_addr, hold_addr);
      end
      if (redirect) begin
        check("req_in_redirect", {31'b0, imem_req}, 32'h0);
        exp_i = redirect_pc & 32'hFFFF_FFFC;
        exp_p = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (s_issue) begin
          check("issue_addr", imem_addr, exp_i);
          exp_i += 32'd4;
        end
        if (instr_valid && instr_ready) begin
          check("pop_pc", instr_pc, exp_p);
          check("pop_instr", instr, word(exp_p));
          exp_p += 32'd4;
          n_pops++;
        end
      end
      if (rv) begin
        void'(mq_a.pop_front());
        void'(mq_c.pop_front());
      end
      if (s_issue) begin
        mq_a.push_back(imem_addr);
        mq_c.push_back(cyc);
        n_grants++;
      end
      check("credit", {31'b0, mq_a.size() <= DEPTH}, 32'h1);
      hold      = imem_req && !imem_gnt && !redirect;
      hold_addr = imem_addr;
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    redirect = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      cycle();
      if (s_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic ok;
  int   t0;
  int   t1;
  int   base;

  initial begin
    passed = 0; total = 0; cyc = 0;
    n_grants = 0; n_pops = 0; rv_pct = 100;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; hold = 1'b0; hold_addr = '0;
    exp_i = RST_PC; exp_p = RST_PC;
    @(negedge clock);

    // 1: reset state, latency, in-order stream
    imem_gnt = 1'b1; instr_ready = 1'b1; rv_pct = 100;
    reset_dut();
    cycle();
    check("rst_valid", {31'b0, s_valid}, 32'h0);
    check("rst_instr", s_instr, 32'h0);
    check("rst_pc", s_pc, 32'h0);
    check("rst_req", {31'b0, s_req}, 32'h1);
    check("rst_addr", s_addr, RST_PC);
    t0 = cyc - 1;
    base = n_pops;
    wait_valid(10, ok);
    check("t1_valid_seen", {31'b0, ok}, 32'h1);
    t1 = cyc - 1;
    check("t1_latency", t1 - t0, 32'd2);
    check("t1_first_pc", s_pc, RST_PC);
    for (int i = 0; i < 10; i++) cycle();
    check("t1_pops", {31'b0, (n_pops - base) >= 3}, 32'h1);

    // 2: consumer stalled, credit limit
    instr_ready = 1'b0;
    reset_dut();
    base = n_grants;
    for (int i = 0; i < 8; i++) cycle();
    check("t2_grants", n_grants - base, 32'd2);
    check("t2_req_low", {31'b0, s_req}, 32'h0);
    check("t2_full", {31'b0, s_valid}, 32'h1);
    check("t2_head", s_pc, 32'h0);
    instr_ready = 1'b1;
    base = n_pops;
    for (int i = 0; i < 10; i++) cycle();
    check("t2_pops", {31'b0, (n_pops - base) >= 3}, 32'h1);

    // 3: request held while grant withheld
    reset_dut();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_addr == 32'h8) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
    check("t3_reach_8", {31'b0, ok}, 32'h1);
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t3_addr", s_addr, 32'h8);
      check("t3_req", {31'b0, s_req}, 32'h1);
    end
    imem_gnt = 1'b1;
    cycle();
    check("t3_grant_8", {31'b0, s_issue}, 32'h1);
    for (int i = 0; i < 6; i++) cycle();

    // 4: redirect with two in flight
    rv_pct = 0;
    reset_dut();
    cycle();
    cycle();
    check("t4_inflight", mq_a.size(), 32'd2);
    redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0;
    cycle();
    check("t4_drain_req", {31'b0, s_req}, 32'h0);
    check("t4_drain_valid", {31'b0, s_valid}, 32'h0);
    rv_pct = 100;
    wait_valid(20, ok);
    check("t4_valid_seen", {31'b0, ok}, 32'h1);
    check("t4_pc", s_pc, 32'h100);
    check("t4_instr", s_instr, word(32'h100));

    // 5: redirect to an unaligned target while granting
    reset_dut();
    for (int i = 0; i < 4; i++) cycle();
    redirect = 1'b1; redirect_pc = 32'h203;
    cycle();
    redirect = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_issue) begin
        ok = 1'b1;
        break;
      end
    end
    check("t5_issue_seen", {31'b0, ok}, 32'h1);
    check("t5_addr", s_addr, 32'h200);
    wait_valid(20, ok);
    check("t5_pc", s_pc, 32'h200);

    // 6: reset with requests in flight
    rv_pct = 0;
    reset_dut();
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    rv_pct = 100;
    cycle();
    check("t6_valid", {31'b0, s_valid}, 32'h0);
    check("t6_req", {31'b0, s_req}, 32'h1);
    check("t6_addr", s_addr, RST_PC);
    wait_valid(20, ok);
    check("t6_pc", s_pc, RST_PC);

    // 7: PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF9;
    cycle();
    redirect = 1'b0;
    base = n_pops;
    for (int i = 0; i < 16; i++) cycle();
    check("t7_pops", {31'b0, (n_pops - base) >= 3}, 32'h1);

    // random traffic
    rv_pct = 60;
    for (int k = 0; k < 4000; k++) begin
      imem_gnt    = ($urandom_range(0, 99) < 70);
      instr_ready = ($urandom_range(0, 99) < 70);
      redirect    = ($urandom_range(0, 99) < 3);
      redirect_pc = ($urandom_range(0, 3) == 0)
                  ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                  : $urandom;
      reset       = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0; redirect = 1'b0;
    imem_gnt = 1'b1; instr_ready = 1'b1; rv_pct = 100;
    base = n_pops;
    for (int i = 0; i < 20; i++) cycle();
    check("final_live", {31'b0, (n_pops - base) >= 5}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
